// File: rtl/alu_wide_sequencer_if.sv
// Request, result and arithmetic-unit byte bus of alu_wide_sequencer.
// The slave modport is the sequencer; the master side is the requester, consumer and arithmetic unit.
interface alu_wide_sequencer_if #(
   parameter int unsigned WORDS = 2
);
   localparam int unsigned W = 8 * WORDS;

   logic           in_valid;
   logic           in_ready;
   logic [2:0]     in_op;
   logic [W-1:0]   in_a;
   logic [W-1:0]   in_b;
   logic           in_cin;

   logic [7:0]     alu_a;
   logic [7:0]     alu_b;
   logic           alu_cin;
   logic [1:0]     alu_s;
   logic [7:0]     alu_d;
   logic           alu_cout;

   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_result;
   logic           out_carry;
   logic           out_zero;
   logic           out_ovf;

   modport master (
      output in_valid, in_op, in_a, in_b, in_cin, out_ready, alu_d, alu_cout,
      input  in_ready, alu_a, alu_b, alu_cin, alu_s,
      input  out_valid, out_result, out_carry, out_zero, out_ovf
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_cin, out_ready, alu_d, alu_cout,
      output in_ready, alu_a, alu_b, alu_cin, alu_s,
      output out_valid, out_result, out_carry, out_zero, out_ovf
   );
endinterface

// File: rtl/alu_wide_sequencer.sv
// Byte-serial sequencer for the 8-bit arithmetic unit: feeds operands LSB first,
// chains carry between bytes, assembles the W-bit result and its flags.
module alu_wide_sequencer #(
   parameter int unsigned WORDS = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_wide_sequencer_if.slave  bus
);
   localparam int unsigned W     = 8 * WORDS;
   localparam int unsigned IDX_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic [W-1:0]       res_q, res_d;
   logic               a_msb_q, a_msb_d;
   logic               b_msb_q, b_msb_d;
   logic [1:0]         s_q, s_d;
   logic               carry_q, carry_d;

   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [W-1:0]       out_result_q, out_result_d;
   logic               out_carry_q, out_carry_d;
   logic               out_zero_q, out_zero_d;
   logic               out_ovf_q, out_ovf_d;
   logic [7:0]         alu_a_q, alu_a_d;
   logic [7:0]         alu_b_q, alu_b_d;
   logic               alu_cin_q, alu_cin_d;
   logic [1:0]         alu_s_q, alu_s_d;

   logic [1:0]         op_s;
   logic               op_cin;
   logic [W-1:0]       a_shift, b_shift;
   logic [W+7:0]       res_cat;
   logic [W-1:0]       res_next;
   logic               eb_msb;
   logic               last_byte;

   // Op decode into (S, initial carry); the reserved code behaves as TFR
   always_comb begin
      op_s   = 2'b10;
      op_cin = 1'b0;
      case (bus.in_op)
         3'b000: begin op_s = 2'b00; op_cin = 1'b0;       end
         3'b001: begin op_s = 2'b00; op_cin = bus.in_cin; end
         3'b010: begin op_s = 2'b01; op_cin = 1'b1;       end
         3'b011: begin op_s = 2'b01; op_cin = bus.in_cin; end
         3'b100: begin op_s = 2'b10; op_cin = 1'b1;       end
         3'b101: begin op_s = 2'b11; op_cin = 1'b0;       end
         default: begin op_s = 2'b10; op_cin = 1'b0;      end
      endcase
   end

   // Operands shift down a byte per RUN cycle; result bytes enter from the top
   assign a_shift   = a_q >> 8;
   assign b_shift   = b_q >> 8;
   assign res_cat   = {bus.alu_d, res_q} >> 8;
   assign res_next  = res_cat[W-1:0];
   assign last_byte = (idx_q == IDX_W'(WORDS - 1));

   always_comb begin
      case (s_q)
         2'b00:   eb_msb = b_msb_q;
         2'b01:   eb_msb = ~b_msb_q;
         2'b10:   eb_msb = 1'b0;
         default: eb_msb = 1'b1;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      a_d          = a_q;
      b_d          = b_q;
      res_d        = res_q;
      a_msb_d      = a_msb_q;
      b_msb_d      = b_msb_q;
      s_d          = s_q;
      carry_d      = carry_q;
      in_ready_d   = in_ready_q;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_carry_d  = out_carry_q;
      out_zero_d   = out_zero_q;
      out_ovf_d    = out_ovf_q;
      alu_a_d      = 8'h00;
      alu_b_d      = 8'h00;
      alu_cin_d    = 1'b0;
      alu_s_d      = 2'b00;

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d        = bus.in_a;
               b_d        = bus.in_b;
               a_msb_d    = bus.in_a[W-1];
               b_msb_d    = bus.in_b[W-1];
               s_d        = op_s;
               carry_d    = op_cin;
               idx_d      = '0;
               res_d      = '0;
               in_ready_d = 1'b0;
               alu_a_d    = bus.in_a[7:0];
               alu_b_d    = bus.in_b[7:0];
               alu_cin_d  = op_cin;
               alu_s_d    = op_s;
               state_d    = RUN;
            end
         end
         RUN: begin
            res_d   = res_next;
            carry_d = bus.alu_cout;
            idx_d   = idx_q + IDX_W'(1);
            a_d     = a_shift;
            b_d     = b_shift;
            if (last_byte) begin
               out_valid_d  = 1'b1;
               out_result_d = res_next;
               out_carry_d  = bus.alu_cout;
               out_zero_d   = (res_next == '0);
               out_ovf_d    = (a_msb_q == eb_msb) && (res_next[W-1] != a_msb_q);
               state_d      = DONE;
            end else begin
               alu_a_d   = a_shift[7:0];
               alu_b_d   = b_shift[7:0];
               alu_cin_d = carry_d;
               alu_s_d   = s_q;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         res_q        <= '0;
         a_msb_q      <= 1'b0;
         b_msb_q      <= 1'b0;
         s_q          <= 2'b00;
         carry_q      <= 1'b0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_carry_q  <= 1'b0;
         out_zero_q   <= 1'b0;
         out_ovf_q    <= 1'b0;
         alu_a_q      <= 8'h00;
         alu_b_q      <= 8'h00;
         alu_cin_q    <= 1'b0;
         alu_s_q      <= 2'b00;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         a_q          <= a_d;
         b_q          <= b_d;
         res_q        <= res_d;
         a_msb_q      <= a_msb_d;
         b_msb_q      <= b_msb_d;
         s_q          <= s_d;
         carry_q      <= carry_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_carry_q  <= out_carry_d;
         out_zero_q   <= out_zero_d;
         out_ovf_q    <= out_ovf_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_cin_q    <= alu_cin_d;
         alu_s_q      <= alu_s_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = out_result_q;
   assign bus.out_carry  = out_carry_q;
   assign bus.out_zero   = out_zero_q;
   assign bus.out_ovf    = out_ovf_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_cin    = alu_cin_q;
   assign bus.alu_s      = alu_s_q;
endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench for alu_wide_sequencer (WORDS=2) closing the loop through an 8-bit arithmetic unit model.
module tb_alu_wide_sequencer;
   localparam int unsigned WORDS = 2;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   logic cin2;

   always #5 clk = ~clk;

   alu_wide_sequencer_if #(.WORDS(WORDS)) bus ();

   alu_wide_sequencer #(.WORDS(WORDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // 8-bit arithmetic unit: D = A + f(S,B) + Cin
   logic [7:0] eb;
   always_comb begin
      case (bus.alu_s)
         2'b00:   eb = bus.alu_b;
         2'b01:   eb = ~bus.alu_b;
         2'b10:   eb = 8'h00;
         default: eb = 8'hFF;
      endcase
      {bus.alu_cout, bus.alu_d} = 9'(bus.alu_a) + 9'(eb) + 9'(bus.alu_cin);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full-width reference: returns {ovf, zero, carry, result}
   function automatic logic [18:0] model(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
      logic [15:0] e;
      logic        c0;
      logic [16:0] s;
      case (op)
         3'b000:  begin e = b;        c0 = 1'b0; end
         3'b001:  begin e = b;        c0 = cin;  end
         3'b010:  begin e = ~b;       c0 = 1'b1; end
         3'b011:  begin e = ~b;       c0 = cin;  end
         3'b100:  begin e = 16'h0000; c0 = 1'b1; end
         3'b101:  begin e = 16'hFFFF; c0 = 1'b0; end
         default: begin e = 16'h0000; c0 = 1'b0; end
      endcase
      s = 17'(a) + 17'(e) + 17'(c0);
      return {(a[15] == e[15]) && (s[15] != a[15]), s[15:0] == 16'h0000, s[16], s[15:0]};
   endfunction

   task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic cin, input logic [15:0] er,
                         input logic ec, input logic ez, input logic eo);
      check({tag, "/idle_ready"}, 32'(bus.in_ready), 1);
      bus.in_op    = op;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check({tag, "/run_ready"}, 32'(bus.in_ready), 0);
      step();
      check({tag, "/early_valid"}, 32'(bus.out_valid), 0);
      cin2 = bus.alu_cin;
      step();
      check({tag, "/valid"}, 32'(bus.out_valid), 1);
      check({tag, "/result"}, 32'(bus.out_result), 32'(er));
      check({tag, "/carry"}, 32'(bus.out_carry), 32'(ec));
      check({tag, "/zero"}, 32'(bus.out_zero), 32'(ez));
      check({tag, "/ovf"}, 32'(bus.out_ovf), 32'(eo));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check({tag, "/valid_drop"}, 32'(bus.out_valid), 0);
      check({tag, "/ready_back"}, 32'(bus.in_ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0]  ops [8];
      logic [15:0] as  [8];
      logic [15:0] bs  [8];
      logic        cs  [8];
      logic [18:0] m;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_op     = 3'b000;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_cin    = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) step();
      check("rst/in_ready", 32'(bus.in_ready), 1);
      check("rst/out_valid", 32'(bus.out_valid), 0);
      check("rst/flags", 32'({bus.out_result, bus.out_carry, bus.out_zero, bus.out_ovf}), 0);
      check("rst/alu", 32'({bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_s}), 0);
      @(negedge clk);
      rst = 1'b0;
      step();

      run_op("add_ff", 3'b000, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
      check("add_ff/cin2", 32'(cin2), 1);
      run_op("sub_eq", 3'b010, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      run_op("sbb", 3'b011, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      run_op("add_ovf", 3'b000, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
      run_op("dec", 3'b101, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      run_op("inc", 3'b100, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

      // Backpressure: result held, stray request ignored
      bus.in_op = 3'b000; bus.in_a = 16'h1234; bus.in_b = 16'h1111; bus.in_cin = 1'b0;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            bus.in_op = 3'b010; bus.in_a = 16'h0001; bus.in_b = 16'h0001; bus.in_valid = 1'b1;
         end
         if (i == 2) bus.in_valid = 1'b0;
         step();
         check("bp/valid", 32'(bus.out_valid), 1);
         check("bp/ready", 32'(bus.in_ready), 0);
         check("bp/result", 32'({bus.out_result, bus.out_carry, bus.out_zero, bus.out_ovf}),
               32'({16'h2345, 3'b000}));
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("bp/valid_drop", 32'(bus.out_valid), 0);
      check("bp/ready_back", 32'(bus.in_ready), 1);
      step();
      step();
      check("bp/no_second", 32'(bus.out_valid), 0);
      check("bp/still_idle", 32'(bus.in_ready), 1);

      // Asynchronous reset in the middle of RUN
      bus.in_op = 3'b000; bus.in_a = 16'h1234; bus.in_b = 16'h1111; bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check("arst/run_alu_a", 32'(bus.alu_a), 32'h34);
      #3;
      rst = 1'b1;
      #1;
      check("arst/in_ready", 32'(bus.in_ready), 1);
      check("arst/out_valid", 32'(bus.out_valid), 0);
      check("arst/outs", 32'({bus.out_result, bus.out_carry, bus.out_zero, bus.out_ovf}), 0);
      check("arst/alu", 32'({bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_s}), 0);
      @(negedge clk);
      rst = 1'b0;
      step();
      step();
      check("arst/no_valid", 32'(bus.out_valid), 0);
      run_op("adc_post", 3'b001, 16'h0102, 16'h0304, 1'b1, 16'h0407, 1'b0, 1'b0, 1'b0);

      // Back-to-back with out_ready tied high; expected spacing is 4 cycles
      ops = '{3'b000, 3'b010, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
      as  = '{16'hA5A5, 16'h0100, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h8000, 16'hBEEF, 16'hCAFE};
      bs  = '{16'h5A5A, 16'h0001, 16'h0001, 16'h0001, 16'h1111, 16'h2222, 16'h1234, 16'hFFFF};
      cs  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.in_op  = ops[i];
         bus.in_a   = as[i];
         bus.in_b   = bs[i];
         bus.in_cin = cs[i];
         check("b2b/ready", 32'(bus.in_ready), 1);
         step();
         step();
         step();
         m = model(ops[i], as[i], bs[i], cs[i]);
         check("b2b/valid", 32'(bus.out_valid), 1);
         check("b2b/busy", 32'(bus.in_ready), 0);
         check("b2b/result", 32'(bus.out_result), 32'(m[15:0]));
         check("b2b/flags", 32'({bus.out_ovf, bus.out_zero, bus.out_carry}), 32'(m[18:16]));
         step();
         check("b2b/valid_drop", 32'(bus.out_valid), 0);
      end
      check("rsv/result", 32'(bus.out_result), 32'hCAFE);
      check("rsv/carry", 32'(bus.out_carry), 0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_wide_sequencer.md
Name: alu_wide_sequencer

Overview:
- Upstream controller for the 8-bit dataflow arithmetic unit, which is eight chained arithmetic segments sharing S.
- Accepts one multi-byte operation through a valid/ready handshake.
- Drives A, B, Cin and S to the unit one byte per cycle, least-significant byte first, and chains Cout into the next byte's Cin.
- Collects the result bytes, computes flags, and presents the result through a valid/ready output handshake.

Parameters:
WORDS, 2, number of 8-bit bytes per operand; the operand width is W = 8*WORDS. Legal range is 1..8.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
in_op  input  3  operation code
in_a  input  W  operand A
in_b  input  W  operand B
in_cin  input  1  carry-in for ADC/SBB (1 = no borrow)
alu_a  output  8  A byte to the arithmetic unit
alu_b  output  8  B byte to the arithmetic unit
alu_cin  output  1  Cin to the arithmetic unit
alu_s  output  2  S to the arithmetic unit (00 B, 01 ~B, 10 zero, 11 all ones)
alu_d  input  8  D byte returned by the arithmetic unit (combinational)
alu_cout  input  1  Cout returned by the arithmetic unit
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_result  output  W  result
out_carry  output  1  final carry-out
out_zero  output  1  result == 0
out_ovf  output  1  signed overflow

Behaviour:
- Reset:
  - State is IDLE.
  - in_ready=1, out_valid=0, and out_result, out_carry, out_zero, out_ovf are all 0.
  - alu_a, alu_b, alu_cin and alu_s are all 0.
  - The byte index, operand and carry registers are cleared.
- Op map, given as (S, initial Cin):
  - 000 ADD = (00, 0)
  - 001 ADC = (00, in_cin)
  - 010 SUB = (01, 1)
  - 011 SBB = (01, in_cin)
  - 100 INC = (10, 1)
  - 101 DEC = (11, 0)
  - 110 TFR = (10, 0)
  - 111 reserved, executes exactly as TFR
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at a clock edge: capture in_a, in_b, S and the initial Cin; set idx=0; go to RUN.
- RUN:
  - in_ready=0.
  - alu_a, alu_b, alu_cin and alu_s are driven from registers only: byte idx of A, byte idx of B, the carry register, and S.
  - alu_d and alu_cout must not feed any output combinationally.
  - At each edge: result byte idx <= alu_d, carry <= alu_cout, idx <= idx+1.
  - When idx==WORDS-1 at the edge, go to DONE.
  - At that same edge, latch the flags:
    - out_carry <= alu_cout.
    - out_zero <= (all W result bits, including the final byte, == 0).
    - out_ovf <= (a_msb == eb_msb) && (d_msb != a_msb), where eb_msb is the effective B msb for S: b_msb, ~b_msb, 0 or 1.
- DONE:
  - out_valid=1, in_ready=0.
  - out_result and the flags are held stable until an edge where out_ready=1; then go to IDLE and set out_valid=0.
  - in_valid is ignored outside IDLE.
- Latency and throughput:
  - For a request accepted at edge k, out_valid rises after edge k+WORDS.
  - Minimum spacing between accepted requests is WORDS+2 cycles.
- alu_* outputs return to 0 in IDLE and in DONE.
- Arithmetic wraps modulo 2^W. The carry convention is carry=1 meaning no borrow for SUB/SBB.
- With WORDS=1, RUN lasts exactly one cycle.
- When out_ready=1 and in_valid=1 in the same DONE cycle, the block returns to IDLE; the request is accepted in the following IDLE cycle, not in the same cycle.
- Reset asserted in any state immediately forces the reset values; the in-flight operation is discarded and no out_valid is produced.

Test Plan:
All scenarios use WORDS=2; the bench closes the loop through the existing 8-bit arithmetic unit.
- ADD 0x00FF+0x0001 -> out_result=0x0100, carry=0, zero=0, ovf=0; out_valid exactly 2 cycles after accept; alu_cin=1 on the second RUN cycle.
- SUB 0x1234-0x1234 -> 0x0000, carry=1, zero=1, ovf=0; SBB 0x0000-0x0001 with in_cin=1 -> 0xFFFF, carry=0.
- ADD 0x7FFF+0x0001 -> 0x8000, ovf=1; DEC 0x0000 -> 0xFFFF, carry=0, ovf=0; INC 0xFFFF -> 0x0000, carry=1, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 pulsed -> result and flags stable, in_ready=0, and no second request captured; release -> exactly one out_valid handshake, then in_ready=1.
- Reset asserted asynchronously mid-RUN (between edges) -> in_ready=1 and all outputs 0 immediately; a following ADC 0x0102+0x0304 with in_cin=1 -> 0x0407.
- Back-to-back requests with out_ready tied to 1: eight random ops including reserved 111 (checked against TFR: result=A, carry=0) -> all results match a reference model, with accept spacing of 4 cycles.
